// File: rtl/barrel_pkg.sv
// Shared sizing constants and FSM state type for the barrel-threaded register file.
package barrel_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_THREADS = 8;
  localparam int REG_COUNT   = 32;
  localparam int REG_IDX_W   = $clog2(REG_COUNT);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset sweep controller: walks every register index once, zeroing it in all
// banks, then parks in RUN and raises ready one cycle later.
module regfile_clear_ctrl
  import barrel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 clr_we,
  output logic [REG_IDX_W-1:0] clr_idx,
  output logic                 ready
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(REG_COUNT - 1);

  rf_state_e             state_r;
  logic [REG_IDX_W-1:0]  idx_r;
  logic                  clr_we_r;
  logic                  ready_r;

  // Sweep FSM with registered clear-enable, index and ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= CLEAR;
      idx_r    <= '0;
      clr_we_r <= 1'b1;
      ready_r  <= 1'b0;
    end else begin
      ready_r <= (state_r == RUN);
      case (state_r)
        CLEAR: begin
          idx_r <= idx_r + 5'd1;
          if (idx_r == LAST_IDX) begin
            state_r  <= RUN;
            clr_we_r <= 1'b0;
          end else begin
            state_r  <= CLEAR;
            clr_we_r <= 1'b1;
          end
        end
        RUN: begin
          state_r  <= RUN;
          clr_we_r <= 1'b0;
        end
        default: begin
          state_r  <= CLEAR;
          idx_r    <= '0;
          clr_we_r <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we  = clr_we_r;
  assign clr_idx = idx_r;
  assign ready   = ready_r;

endmodule

// File: rtl/barrel_regfile.sv
// Multi-thread register file: one 32-entry bank per hardware thread, 1-cycle read.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback to the read ports.
module barrel_regfile
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH   = barrel_pkg::DATA_WIDTH,
  parameter int NUM_THREADS  = barrel_pkg::NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reg_write_w,
  input  logic [4:0]              rd_w,
  input  logic [BITS_THREADS-1:0] tid_w,
  input  logic [DATA_WIDTH-1:0]   result_w,
  input  logic [4:0]              rs1_d,
  input  logic [4:0]              rs2_d,
  input  logic [BITS_THREADS-1:0] tid_d,
  output logic [DATA_WIDTH-1:0]   rd1_e,
  output logic [DATA_WIDTH-1:0]   rd2_e,
  output logic                    ready
);

  localparam logic [BITS_THREADS:0] THREAD_LIMIT = NUM_THREADS[BITS_THREADS:0];

  logic [DATA_WIDTH-1:0] mem_r [NUM_THREADS][REG_COUNT];

  logic                  clr_we_s;
  logic [4:0]            clr_idx_s;
  logic                  tid_ok_w_s;
  logic                  tid_ok_d_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd1_val_s;
  logic [DATA_WIDTH-1:0] rd2_val_s;

  regfile_clear_ctrl u_clear_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we_s),
    .clr_idx (clr_idx_s),
    .ready   (ready)
  );

  // Thread ids past the last real bank never touch storage.
  assign tid_ok_w_s = ({1'b0, tid_w} < THREAD_LIMIT);
  assign tid_ok_d_s = ({1'b0, tid_d} < THREAD_LIMIT);
  assign wr_en_s    = !rst && !clr_we_s && reg_write_w && (rd_w != 5'd0) && tid_ok_w_s;

  // Storage update: sweep zeroes one index across all banks, otherwise writeback.
  always_ff @(posedge clk) begin
    if (!rst && clr_we_s) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        mem_r[t][clr_idx_s] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[tid_w][rd_w] <= result_w;
    end
  end

  // Read-port selection: x0 and invalid threads read zero, optional write-first forward.
  always_comb begin
    rd1_val_s = '0;
    rd2_val_s = '0;
    if (!tid_ok_d_s || (rs1_d == 5'd0)) begin
      rd1_val_s = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (tid_w == tid_d) && (rd_w == rs1_d)) begin
      rd1_val_s = result_w;
    end
`endif
    else begin
      rd1_val_s = mem_r[tid_d][rs1_d];
    end
    if (!tid_ok_d_s || (rs2_d == 5'd0)) begin
      rd2_val_s = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en_s && (tid_w == tid_d) && (rd_w == rs2_d)) begin
      rd2_val_s = result_w;
    end
`endif
    else begin
      rd2_val_s = mem_r[tid_d][rs2_d];
    end
  end

  // Registered read outputs, held at zero while the sweep is running.
  always_ff @(posedge clk) begin
    if (rst || clr_we_s) begin
      rd1_e <= '0;
      rd2_e <= '0;
    end else begin
      rd1_e <= rd1_val_s;
      rd2_e <= rd2_val_s;
    end
  end

endmodule

// File: tb/tb_barrel_regfile.sv
// Self-checking bench for barrel_regfile: clear sweep timing, table-driven RUN
// accesses, x0 behaviour, same-cycle hazard and reset during the sweep.
module tb_barrel_regfile;

  localparam int DW = 32;
  localparam int TW = 3;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] SAME_CYC_VAL = 32'h0000_0022;
`else
  localparam logic [31:0] SAME_CYC_VAL = 32'h0000_0011;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_write_w = 1'b0;
  logic [4:0]    rd_w = 5'd0;
  logic [TW-1:0] tid_w = 3'd0;
  logic [DW-1:0] result_w = 32'd0;
  logic [4:0]    rs1_d = 5'd0;
  logic [4:0]    rs2_d = 5'd0;
  logic [TW-1:0] tid_d = 3'd0;
  logic [DW-1:0] rd1_e;
  logic [DW-1:0] rd2_e;
  logic          ready;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       tag;
  } exp_t;

  typedef struct {
    logic          we;
    logic [4:0]    rd;
    logic [TW-1:0] tw;
    logic [31:0]   data;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [TW-1:0] td;
    logic [31:0]   e1;
    logic [31:0]   e2;
    string         tag;
  } vec_t;

  localparam int N_VEC = 13;

  exp_t sb_q[$];
  vec_t vecs[N_VEC];
  int   total = 0;
  int   bad = 0;
  int   low_edges = 0;

  barrel_regfile #(
    .DATA_WIDTH   (DW),
    .NUM_THREADS  (8),
    .BITS_THREADS (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .tid_w       (tid_w),
    .result_w    (result_w),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .tid_d       (tid_d),
    .rd1_e       (rd1_e),
    .rd2_e       (rd2_e),
    .ready       (ready)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] rd, input logic [TW-1:0] tw,
                              input logic [31:0] data, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [TW-1:0] td, input logic [31:0] e1, input logic [31:0] e2,
                              input string tag);
    vec_t v;
    v.we = we; v.rd = rd; v.tw = tw; v.data = data;
    v.rs1 = rs1; v.rs2 = rs2; v.td = td;
    v.e1 = e1; v.e2 = e2; v.tag = tag;
    return v;
  endfunction

  // One clock: drive write+read, queue expected read data, check after the edge.
  task automatic cycle(input logic we, input logic [4:0] rd, input logic [TW-1:0] tw,
                       input logic [31:0] data, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [TW-1:0] td, input logic [31:0] e1, input logic [31:0] e2,
                       input string tag);
    exp_t item;
    reg_write_w = we;
    rd_w        = rd;
    tid_w       = tw;
    result_w    = data;
    rs1_d       = rs1;
    rs2_d       = rs2;
    tid_d       = td;
    item.e1  = e1;
    item.e2  = e2;
    item.tag = tag;
    sb_q.push_back(item);
    @(posedge clk);
    low_edges++;
    #1;
    reg_write_w = 1'b0;
    item = sb_q.pop_front();
    check({item.tag, "_rd1"}, rd1_e, item.e1);
    check({item.tag, "_rd2"}, rd2_e, item.e2);
    // ready rises 32 cycles after the first edge with rst low, i.e. on edge 33.
    check({item.tag, "_ready"}, {31'd0, ready}, (low_edges >= 33) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst         = 1'b1;
    reg_write_w = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rd1"}, rd1_e, 32'd0);
    check({tag, "_rd2"}, rd2_e, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    rst       = 1'b0;
    low_edges = 0;
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 5'd7,  3'd2, 32'h1234_5678, 5'd1,  5'd2,  3'd2, 32'd0,          32'd0,        "wr_t2x7");
    vecs[1]  = mk(1'b0, 5'd0,  3'd0, 32'h0,         5'd7,  5'd0,  3'd2, 32'h1234_5678,  32'd0,        "rd_t2x7");
    vecs[2]  = mk(1'b0, 5'd0,  3'd0, 32'h0,         5'd7,  5'd7,  3'd1, 32'd0,          32'd0,        "rd_t1x7");
    vecs[3]  = mk(1'b1, 5'd0,  3'd0, 32'hFFFF_FFFF, 5'd0,  5'd0,  3'd0, 32'd0,          32'd0,        "wr_x0_t0");
    vecs[4]  = mk(1'b1, 5'd0,  3'd5, 32'hFFFF_FFFF, 5'd0,  5'd7,  3'd5, 32'd0,          32'd0,        "wr_x0_t5");
    vecs[5]  = mk(1'b1, 5'd9,  3'd4, 32'h0000_0011, 5'd5,  5'd5,  3'd3, 32'd0,          32'd0,        "rd_t3x5");
    vecs[6]  = mk(1'b1, 5'd9,  3'd4, 32'h0000_0022, 5'd9,  5'd9,  3'd4, SAME_CYC_VAL,   SAME_CYC_VAL, "same_cyc");
    vecs[7]  = mk(1'b0, 5'd0,  3'd0, 32'h0,         5'd9,  5'd7,  3'd4, 32'h0000_0022,  32'd0,        "rd_t4x9");
    vecs[8]  = mk(1'b1, 5'd31, 3'd7, 32'hA5A5_A5A5, 5'd7,  5'd31, 3'd2, 32'h1234_5678,  32'd0,        "wr_t7x31");
    vecs[9]  = mk(1'b0, 5'd3,  3'd6, 32'hBAD0_BAD0, 5'd31, 5'd9,  3'd7, 32'hA5A5_A5A5,  32'd0,        "rd_t7x31");
    vecs[10] = mk(1'b0, 5'd0,  3'd0, 32'h0,         5'd3,  5'd0,  3'd6, 32'd0,          32'd0,        "no_we");
    vecs[11] = mk(1'b1, 5'd7,  3'd1, 32'h0F0F_0F0F, 5'd7,  5'd1,  3'd2, 32'h1234_5678,  32'd0,        "wr_t1x7");
    vecs[12] = mk(1'b0, 5'd0,  3'd0, 32'h0,         5'd7,  5'd7,  3'd1, 32'h0F0F_0F0F,  32'h0F0F_0F0F, "rd_t1x7b");

    do_reset("por");

    // Sweep: cycles 0..32 after release; the write at cycle 10 must be dropped.
    for (int c = 0; c < 33; c++) begin
      cycle((c == 10), 5'd5, 3'd3, 32'hDEAD_BEEF, 5'd5, 5'd5, 3'd3, 32'd0, 32'd0,
            $sformatf("sweep%0d", c));
    end
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd5, 5'd0, 3'd3, 32'd0, 32'd0, "dropped_wr");

    for (int i = 0; i < N_VEC; i++) begin
      cycle(vecs[i].we, vecs[i].rd, vecs[i].tw, vecs[i].data, vecs[i].rs1, vecs[i].rs2,
            vecs[i].td, vecs[i].e1, vecs[i].e2, vecs[i].tag);
    end

    for (int t = 0; t < 8; t++) begin
      cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd0, 5'd0, TW'(t), 32'd0, 32'd0, $sformatf("x0_t%0d", t));
    end

    // Reset from RUN, then again mid-sweep at sweep cycle 15.
    do_reset("run_rst");
    for (int c = 0; c < 15; c++) begin
      cycle((c == 5), 5'd7, 3'd2, 32'h5555_AAAA, 5'd7, 5'd9, 3'd2, 32'd0, 32'd0,
            $sformatf("sweepb%0d", c));
    end
    do_reset("mid_rst");
    for (int c = 0; c < 33; c++) begin
      cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd7, 5'd31, 3'd2, 32'd0, 32'd0, $sformatf("sweepc%0d", c));
    end
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd7,  5'd7,  3'd2, 32'd0, 32'd0, "post_t2x7");
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd9,  5'd9,  3'd4, 32'd0, 32'd0, "post_t4x9");
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd31, 5'd7,  3'd7, 32'd0, 32'd0, "post_t7x31");
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd7,  5'd7,  3'd1, 32'd0, 32'd0, "post_t1x7");

    // Functional sanity after the restart: the write path still works.
    cycle(1'b1, 5'd12, 3'd6, 32'hC0FF_EE00, 5'd0, 5'd0, 3'd6, 32'd0, 32'd0, "wr_t6x12");
    cycle(1'b0, 5'd0, 3'd0, 32'd0, 5'd12, 5'd12, 3'd6, 32'hC0FF_EE00, 32'hC0FF_EE00, "rd_t6x12");

    check("sb_drain", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
